mipi_byte_aligner: RTL and testbench

- Per-lane word aligner that sits directly downstream of the D-PHY receive stage. It consumes that stage's raw, unaligned 8-bit byte-clock stream (bit 0 = earliest received bit).
- In HUNT, it searches for the HS sync byte 0xB8 at every bit offset. Once found, it locks that offset and emits byte-aligned payload with a valid strobe to the CSI-2 packet decoder.
- One instance per lane; all instances run on the lane byte clock.

---
 rtl/mipi_byte_aligner.sv | 183 ++++++++++++++++++
 tb/tb_mipi_byte_aligner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_byte_aligner.sv
// Per-lane HS sync hunter and byte aligner behind the D-PHY rx deserialiser.
// Build option MIPI_SYNC_ERR_TOL_EN also accepts a sync byte with one bit in error.

module mipi_byte_aligner_cand #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         K         = 0,
  parameter bit         TOL       = 1'b0
) (
  input  logic [15:0] i_win,
  output logic        o_exact,
  output logic        o_hit
);
  localparam logic [7:0] LEAD_MASK = 8'((1 << K) - 1);

  logic [7:0] w_cand;
  logic [7:0] w_diff;
  logic       w_lead_ok;
  logic       w_one_bit;

  assign w_cand    = 8'(i_win >> K);
  // bits that precede the candidate in this window must still be HS-zero
  assign w_lead_ok = (i_win[7:0] & LEAD_MASK) == 8'h00;
  assign w_diff    = w_cand ^ SYNC_BYTE;
  assign w_one_bit = (w_diff != 8'h00) && ((w_diff & (w_diff - 8'd1)) == 8'h00);
  assign o_exact   = w_lead_ok && (w_diff == 8'h00);
  assign o_hit     = o_exact || (TOL && w_lead_ok && w_one_bit);
endmodule

module mipi_byte_aligner #(
  parameter logic [7:0] SYNC_BYTE     = 8'hB8,
  parameter int         LEADER_BYTES  = 1,
  parameter int         MAX_PKT_BYTES = 4096
) (
  input  logic       I_Mipi_CSI_Byte_CLK,
  input  logic       Rst_n,
  input  logic [7:0] I_Byte_Data,
  input  logic       I_Unlock,
  output logic [7:0] O_Aligned_Data,
  output logic       O_Aligned_Valid,
  output logic       O_Sot,
  output logic       O_Sot_Err,
  output logic       O_Locked,
  output logic [2:0] O_Offset,
  output logic       O_Timeout_Err
);
  localparam int NUM_CAND = 8;
`ifdef MIPI_SYNC_ERR_TOL_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif
  localparam logic [3:0]  LEADER_MIN = 4'(LEADER_BYTES);
  localparam logic [15:0] PKT_MAX    = 16'(MAX_PKT_BYTES);

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]          r_prev;
  logic [3:0]          r_zero_run;
  logic [15:0]         r_cnt;
  logic [2:0]          r_off;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_sot;
  logic                r_to;

  logic [15:0]         w_win;
  logic [NUM_CAND-1:0] w_exact;
  logic [NUM_CAND-1:0] w_hit;
  logic [NUM_CAND-1:0] w_sel;
  logic [2:0]          w_k;
  logic                w_hunt;
  logic                w_leader_ok;
  logic                w_match;
  logic                w_expire;
  logic                w_capture;
  logic                w_sot_set;
  logic                w_to_set;

  assign w_win = {I_Byte_Data, r_prev};

  generate
    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
      mipi_byte_aligner_cand #(
        .SYNC_BYTE(SYNC_BYTE),
        .K        (g),
        .TOL      (TOL)
      ) u_cand (
        .i_win  (w_win),
        .o_exact(w_exact[g]),
        .o_hit  (w_hit[g])
      );
    end
  endgenerate

  // an exact match anywhere beats a tolerated one; lowest offset wins within a class
  assign w_sel = (w_exact != '0) ? w_exact : w_hit;

  always_comb begin
    w_k = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (w_sel[i]) w_k = 3'(i);
  end

  assign w_hunt      = (r_state == ST_HUNT);
  assign w_leader_ok = (r_zero_run >= LEADER_MIN);
  assign w_match     = w_hunt && w_leader_ok && (w_sel != '0);
  assign w_expire    = (r_cnt == PKT_MAX);

  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT:   if (w_match) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (I_Unlock || w_expire) w_state_nxt = ST_HUNT;
      default:   w_state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    O_Locked  = 1'b0;
    w_capture = 1'b0;
    w_sot_set = 1'b0;
    w_to_set  = 1'b0;
    case (r_state)
      ST_HUNT: w_sot_set = w_match;
      ST_LOCKED: begin
        O_Locked  = 1'b1;
        w_capture = !I_Unlock && !w_expire;
        w_to_set  = w_expire && !I_Unlock;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_prev     <= '0;
      r_zero_run <= '0;
      r_cnt      <= '0;
      r_off      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sot      <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      r_prev  <= I_Byte_Data;
      r_valid <= w_capture;
      r_sot   <= w_sot_set;
      r_to    <= w_to_set;
      // held at zero while locked so a fresh hunt only trusts bytes seen after unlock
      if (!w_hunt)                 r_zero_run <= '0;
      else if (r_prev != 8'h00)    r_zero_run <= '0;
      else if (r_zero_run != 4'hF) r_zero_run <= r_zero_run + 4'd1;
      if (w_sot_set)      r_cnt <= '0;
      else if (w_capture) r_cnt <= r_cnt + 16'd1;
      if (w_sot_set) r_off  <= w_k;
      if (w_capture) r_data <= 8'(w_win >> r_off);
    end
  end

`ifdef MIPI_SYNC_ERR_TOL_EN
  logic r_sot_err;
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) r_sot_err <= 1'b0;
    else        r_sot_err <= w_sot_set && (w_exact == '0);
  end
  assign O_Sot_Err = r_sot_err;
`else
  assign O_Sot_Err = 1'b0;
`endif

  assign O_Aligned_Data  = r_data;
  assign O_Aligned_Valid = r_valid;
  assign O_Sot           = r_sot;
  assign O_Offset        = r_off;
  assign O_Timeout_Err   = r_to;
endmodule

// File: tb/tb_mipi_byte_aligner.sv
// Bench for mipi_byte_aligner: bit-stream reference model plus directed frame checks.
module tb_mipi_byte_aligner;
  localparam logic [7:0] SYNC   = 8'hB8;
  localparam int         LEADER = 1;
  localparam int         MAXB   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       unl = 1'b0;
  logic [7:0] O_Aligned_Data;
  logic       O_Aligned_Valid, O_Sot, O_Sot_Err, O_Locked, O_Timeout_Err;
  logic [2:0] O_Offset;

  always #5 clk = ~clk;

  mipi_byte_aligner #(.SYNC_BYTE(SYNC), .LEADER_BYTES(LEADER), .MAX_PKT_BYTES(MAXB)) dut (
    .I_Mipi_CSI_Byte_CLK(clk), .Rst_n(rst_n), .I_Byte_Data(din), .I_Unlock(unl),
    .O_Aligned_Data(O_Aligned_Data), .O_Aligned_Valid(O_Aligned_Valid), .O_Sot(O_Sot),
    .O_Sot_Err(O_Sot_Err), .O_Locked(O_Locked), .O_Offset(O_Offset), .O_Timeout_Err(O_Timeout_Err)
  );

  int tests = 0, fails = 0, cycn = 0;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: raw byte history, stream bit n = hist[n/8][n%8]; hist[0] is the reset prev byte
  logic [7:0] hist[$];
  int         base, m_cnt, m_sync;
  bit         m_locked;
  logic [7:0] e_data;
  logic [2:0] e_off;
  bit         e_valid, e_sot, e_soterr, e_to;

  function automatic bit sbit(int n);
    logic [7:0] b;
    b = hist[n / 8];
    return b[n % 8];
  endfunction

  function automatic logic [7:0] sbyte(int n);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = sbit(n + b);
    return r;
  endfunction

  task automatic mreset();
    hist.delete(); hist.push_back(8'h00);
    base = 0; m_locked = 0; m_cnt = 0; m_sync = 0;
    e_data = 8'h00; e_off = 3'd0; e_valid = 0; e_sot = 0; e_soterr = 0; e_to = 0;
  endtask

  task automatic mstep(logic [7:0] d, logic u);
    int i, zr, hb, kx, kn, k;
    bit lz;
    logic [7:0] wv;
    hist.push_back(d);
    i = hist.size() - 1;
    e_sot = 0; e_soterr = 0; e_to = 0; e_valid = 0;
    if (m_locked) begin
      if (u) begin m_locked = 0; base = i; end
      else if (m_cnt == MAXB) begin m_locked = 0; base = i; e_to = 1; end
      else begin
        e_valid = 1;
        e_data  = sbyte(m_sync + 8 * (m_cnt + 1));
        m_cnt++;
      end
    end else begin
      zr = 0;
      for (int j = i - 2; j >= base && j >= 0 && zr < 15; j--) begin
        if (hist[j] != 8'h00) break;
        zr++;
      end
      hb = 8 * (i - 1); kx = -1; kn = -1;
      if (zr >= LEADER) begin
        for (int kk = 0; kk < 8; kk++) begin
          lz = 1;
          for (int b = 0; b < kk; b++) if (sbit(hb + b)) lz = 0;
          wv = sbyte(hb + kk);
          if (lz && wv == SYNC && kx < 0) kx = kk;
          if (lz && $countones(wv ^ SYNC) == 1 && kn < 0) kn = kk;
        end
      end
`ifndef MIPI_SYNC_ERR_TOL_EN
      kn = -1;
`endif
      if (kx >= 0 || kn >= 0) begin
        k = (kx >= 0) ? kx : kn;
        m_locked = 1; m_cnt = 0; m_sync = hb + k;
        e_sot = 1; e_soterr = (kx < 0); e_off = 3'(k);
      end
    end
  endtask

  task automatic cyc(logic [7:0] d, logic u);
    din = d; unl = u;
    mstep(d, u);
    @(posedge clk); #1;
    cycn++;
    chk($sformatf("data@%0d", cycn),   16'(O_Aligned_Data),  16'(e_data));
    chk($sformatf("valid@%0d", cycn),  16'(O_Aligned_Valid), 16'(e_valid));
    chk($sformatf("sot@%0d", cycn),    16'(O_Sot),           16'(e_sot));
    chk($sformatf("soterr@%0d", cycn), 16'(O_Sot_Err),       16'(e_soterr));
    chk($sformatf("locked@%0d", cycn), 16'(O_Locked),        16'(m_locked));
    chk($sformatf("offset@%0d", cycn), 16'(O_Offset),        16'(e_off));
    chk($sformatf("tmo@%0d", cycn),    16'(O_Timeout_Err),   16'(e_to));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_data"}, 16'(O_Aligned_Data), 16'h0);
    chk({tag, "_valid"}, 16'(O_Aligned_Valid), 16'h0);
    chk({tag, "_sot"}, 16'(O_Sot), 16'h0);
    chk({tag, "_soterr"}, 16'(O_Sot_Err), 16'h0);
    chk({tag, "_locked"}, 16'(O_Locked), 16'h0);
    chk({tag, "_off"}, 16'(O_Offset), 16'h0);
    chk({tag, "_tmo"}, 16'(O_Timeout_Err), 16'h0);
  endtask

  // frame driver: unlock schedule -1 none, -2 on the expiry cycle, n after n captured bytes
  logic [7:0] pl_q[$];
  logic [7:0] obs[$];
  int c_sot, c_err, c_to, c_off, f_unl;
  bit f_fired;

  task automatic clr();
    obs.delete(); c_sot = 0; c_err = 0; c_to = 0; c_off = 0; f_fired = 0;
  endtask

  task automatic emit(logic [7:0] b);
    logic u;
    u = 1'b0;
    if (f_unl == -2) u = m_locked && (m_cnt == MAXB);
    else if (f_unl >= 0 && !f_fired && m_locked && m_cnt == f_unl) begin u = 1'b1; f_fired = 1; end
    cyc(b, u);
    if (O_Aligned_Valid) obs.push_back(O_Aligned_Data);
    if (O_Sot) begin c_sot++; c_off = int'(O_Offset); end
    if (O_Sot_Err) c_err++;
    if (O_Timeout_Err) c_to++;
  endtask

  task automatic frame(int nz, int off, logic [7:0] sy, int un, int tail);
    bit bq[$];
    logic [7:0] b;
    for (int j = 0; j < nz * 8 + off; j++) bq.push_back(1'b0);
    for (int j = 0; j < 8; j++) bq.push_back(sy[j]);
    foreach (pl_q[p]) for (int j = 0; j < 8; j++) bq.push_back(pl_q[p][j]);
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    for (int j = 0; j < tail * 8; j++) bq.push_back(1'b0);
    clr(); f_unl = un;
    for (int j = 0; j < bq.size(); j += 8) begin
      for (int x = 0; x < 8; x++) b[x] = bq[j + x];
      emit(b);
    end
    for (int g = 0; g < 40 && m_locked; g++) emit(8'h00);
  endtask

  task automatic fchk(string tag, int esot, int eoff, int en, int eto, int eerr);
    chk({tag, "_sotcnt"}, 16'(c_sot), 16'(esot));
    if (esot > 0) chk({tag, "_off"}, 16'(c_off), 16'(eoff));
    chk({tag, "_nbytes"}, 16'(obs.size()), 16'(en));
    chk({tag, "_tmocnt"}, 16'(c_to), 16'(eto));
    chk({tag, "_errcnt"}, 16'(c_err), 16'(eerr));
    for (int j = 0; j < obs.size() && j < en; j++)
      chk($sformatf("%s_b%0d", tag, j), 16'(obs[j]), 16'((j < pl_q.size()) ? pl_q[j] : 8'h00));
  endtask

  task automatic rnd_payload(int n);
    pl_q.delete();
    for (int j = 0; j < n; j++) pl_q.push_back(8'($urandom) | 8'h80);
  endtask

  initial begin
    int len, un, nz, off;
    // reset held with random input
    rst_n = 1'b0;
    for (int j = 0; j < 5; j++) begin
      din = 8'($urandom); unl = 1'($urandom);
      @(posedge clk); #1;
      chk_zero($sformatf("rst%0d", j));
    end
    rst_n = 1'b1; unl = 1'b0;
    mreset();
    clr(); f_unl = -1;
    for (int j = 0; j < 6; j++) emit(8'h00);
    chk("idle_sotcnt", 16'(c_sot), 16'h0);

    pl_q = '{8'h12, 8'h34, 8'h56};
    frame(3, 3, SYNC, 3, 4);
    fchk("off3", 1, 3, 3, 0, 0);

    pl_q = '{8'hAA, 8'h55};
    frame(2, 0, SYNC, 2, 4);
    fchk("off0", 1, 0, 2, 0, 0);

    // unlock while hunting has no effect
    clr(); f_unl = -1;
    cyc(8'h00, 1'b1); cyc(8'h00, 1'b0); cyc(8'h00, 1'b1);
    chk("hunt_unlock", 16'(O_Locked), 16'h0);

    rnd_payload(4);
    frame(3, 2, SYNC, 1, 4);
    fchk("unl1", 1, 2, 1, 0, 0);
    rnd_payload(4);
    frame(2, 5, SYNC, 3, 4);
    fchk("relock5", 1, 5, 3, 0, 0);

    // timeout; payload carries a sync byte that must pass through
    rnd_payload(12); pl_q[3] = SYNC;
    frame(2, 1, SYNC, -1, 4);
    fchk("tmo", 1, 1, 8, 1, 0);
    rnd_payload(12);
    frame(2, 6, SYNC, -2, 4);
    fchk("tmo_unl", 1, 6, 8, 0, 0);

    // reset in the middle of a packet
    clr(); f_unl = -1;
    emit(8'h00); emit(8'h00); emit(SYNC); emit(8'h91); emit(8'h92); emit(8'h93);
    chk("mid_locked", 16'(O_Locked), 16'h1);
    rst_n = 1'b0;
    #2;
    chk_zero("midrst_async");
    @(posedge clk); #1;
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    mreset();

    pl_q = '{8'hC3, 8'h9A};
    frame(3, 2, 8'hB9, 2, 4);
`ifdef MIPI_SYNC_ERR_TOL_EN
    fchk("tol", 1, 2, 2, 0, 1);
`else
    fchk("tol", 0, 0, 0, 0, 0);
`endif

    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 10);
      rnd_payload(len);
      nz  = $urandom_range(1, 4);
      off = $urandom_range(0, 7);
      un  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, (len < MAXB) ? len : MAXB);
      frame(nz, off, SYNC, un, 3);
      fchk($sformatf("rnd%0d", f), 1, off, (un < 0) ? MAXB : un, (un < 0) ? 1 : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
